// File: rtl/edm_pkg.sv
// rtl/edm_pkg.sv - shared FSM encoding and defaults for the EDM pulse generator
package edm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TON  = 2'd1,
        ST_TOFF = 2'd2
    } edm_state_t;

    localparam int CNT_W_DEF    = 16;
    localparam int MIN_TOFF_DEF = 4;

endpackage

// File: rtl/edm_pulse_gen_if.sv
// rtl/edm_pulse_gen_if.sv - command/ack handshake between the SPI command decoder and the pulse generator
interface edm_pulse_gen_if #(
    parameter int CNT_W = edm_pkg::CNT_W_DEF
) ();

    logic             machine_start;
    logic             machine_start_ack;
    logic             machine_stop;
    logic             machine_stop_ack;
    logic [CNT_W-1:0] Ton_data;
    logic             change_Ton;
    logic             change_Ton_ack;
    logic [CNT_W-1:0] Toff_data;
    logic             change_Toff;
    logic             change_Toff_ack;

    modport master (
        output machine_start, machine_stop,
        output Ton_data, change_Ton,
        output Toff_data, change_Toff,
        input  machine_start_ack, machine_stop_ack,
        input  change_Ton_ack, change_Toff_ack
    );

    modport slave (
        input  machine_start, machine_stop,
        input  Ton_data, change_Ton,
        input  Toff_data, change_Toff,
        output machine_start_ack, machine_stop_ack,
        output change_Ton_ack, change_Toff_ack
    );

endinterface

// File: rtl/edm_rr_pick.sv
// rtl/edm_rr_pick.sv - combinational round-robin finder: first set mask bit strictly after ptr, wrapping
module edm_rr_pick #(
    parameter int N_CH  = 8,
    parameter int PTR_W = 3
) (
    input  logic [N_CH-1:0]  mask,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    // Scan farthest offset first so the nearest enabled channel overwrites last.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N_CH; i >= 1; i--) begin
            if (mask[PTR_W'((int'(ptr) + i) % N_CH)]) begin
                idx   = PTR_W'((int'(ptr) + i) % N_CH);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/edm_pulse_gen.sv
// rtl/edm_pulse_gen.sv - N-channel round-robin Ton/Toff discharge pulse generator
// Optional SHORT_CUT_EN: short_flag truncates the running pulse and doubles the next Toff.
module edm_pulse_gen
    import edm_pkg::*;
#(
    parameter int N_CH     = 8,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int MIN_TOFF = MIN_TOFF_DEF,
    parameter int PCNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    edm_pulse_gen_if.slave    cmd,
    input  logic [N_CH-1:0]   chan_mask,
    input  logic              short_flag,
    output logic [N_CH-1:0]   pwm,
    output logic              pwm_q,
    output logic              running,
    output logic [PCNT_W-1:0] pulse_cnt
);

    localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CNT_W-1:0] MIN_TOFF_C = CNT_W'((MIN_TOFF < 1) ? 1 : MIN_TOFF);

    edm_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] ton_act;
    logic [CNT_W-1:0] toff_act;
    logic [CNT_W-1:0] ton_sh;
    logic [CNT_W-1:0] toff_sh;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_valid;
    logic             short_hit;

`ifdef SHORT_CUT_EN
    assign short_hit = short_flag;
`else
    logic short_unused;
    assign short_unused = short_flag;
    assign short_hit    = 1'b0;
`endif

    function automatic logic [CNT_W-1:0] clamp_ton(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    function automatic logic [CNT_W-1:0] clamp_toff(input logic [CNT_W-1:0] v);
        return (v < MIN_TOFF_C) ? MIN_TOFF_C : v;
    endfunction

    function automatic logic [CNT_W-1:0] sat_double(input logic [CNT_W-1:0] v);
        logic [CNT_W:0] d;
        d = {v, 1'b0};
        return d[CNT_W] ? '1 : d[CNT_W-1:0];
    endfunction

    edm_rr_pick #(
        .N_CH  (N_CH),
        .PTR_W (PTR_W)
    ) u_pick (
        .mask  (chan_mask),
        .ptr   (ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                 <= ST_IDLE;
            cnt                   <= '0;
            ton_act               <= CNT_W'(1);
            toff_act              <= MIN_TOFF_C;
            ton_sh                <= CNT_W'(1);
            toff_sh               <= MIN_TOFF_C;
            ptr                   <= '0;
            pwm                   <= '0;
            pwm_q                 <= 1'b0;
            running               <= 1'b0;
            pulse_cnt             <= '0;
            cmd.machine_start_ack <= 1'b0;
            cmd.machine_stop_ack  <= 1'b0;
            cmd.change_Ton_ack    <= 1'b0;
            cmd.change_Toff_ack   <= 1'b0;
        end else begin
            cmd.machine_start_ack <= cmd.machine_start & ~cmd.machine_stop;
            cmd.machine_stop_ack  <= cmd.machine_stop;
            cmd.change_Ton_ack    <= cmd.change_Ton;
            cmd.change_Toff_ack   <= cmd.change_Toff;

            if (cmd.change_Ton) begin
                ton_sh <= clamp_ton(cmd.Ton_data);
            end
            if (cmd.change_Toff) begin
                toff_sh <= clamp_toff(cmd.Toff_data);
            end

            if (cmd.machine_stop) begin
                state   <= ST_IDLE;
                pwm     <= '0;
                pwm_q   <= 1'b0;
                running <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cmd.machine_start) begin
                            state     <= ST_TOFF;
                            cnt       <= toff_act - CNT_W'(1);
                            pwm_q     <= 1'b1;
                            running   <= 1'b1;
                            pulse_cnt <= '0;
                        end
                    end
                    ST_TOFF: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_W'(1);
                        end else if (!pick_valid) begin
                            cnt <= toff_act - CNT_W'(1);
                        end else begin
                            // Shadows become active only here, so a pulse in flight never changes.
                            state     <= ST_TON;
                            pwm       <= N_CH'(1) << pick_idx;
                            pulse_cnt <= pulse_cnt + PCNT_W'(1);
                            ptr       <= pick_idx;
                            ton_act   <= ton_sh;
                            toff_act  <= toff_sh;
                            cnt       <= ton_sh - CNT_W'(1);
                        end
                    end
                    ST_TON: begin
                        if (short_hit) begin
                            state <= ST_TOFF;
                            pwm   <= '0;
                            cnt   <= sat_double(toff_act) - CNT_W'(1);
                        end else if (cnt == '0) begin
                            state <= ST_TOFF;
                            pwm   <= '0;
                            cnt   <= toff_act - CNT_W'(1);
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        pwm     <= '0;
                        pwm_q   <= 1'b0;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_edm_pulse_gen.sv
// tb/tb_edm_pulse_gen.sv - self-checking bench for edm_pulse_gen against a pulse-schedule model
module tb_edm_pulse_gen;
    import edm_pkg::*;

    localparam int N_CH     = 8;
    localparam int CNT_W    = 16;
    localparam int PCNT_W   = 32;
    localparam int MIN_TOFF = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N_CH-1:0]   chan_mask;
    logic              short_flag;
    logic [N_CH-1:0]   pwm;
    logic              pwm_q;
    logic              running;
    logic [PCNT_W-1:0] pulse_cnt;

    edm_pulse_gen_if #(.CNT_W(CNT_W)) cmd_if ();

    edm_pulse_gen #(
        .N_CH     (N_CH),
        .CNT_W    (CNT_W),
        .MIN_TOFF (MIN_TOFF),
        .PCNT_W   (PCNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (cmd_if),
        .chan_mask  (chan_mask),
        .short_flag (short_flag),
        .pwm        (pwm),
        .pwm_q      (pwm_q),
        .running    (running),
        .pulse_cnt  (pulse_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned start;
        int          ch;
        int unsigned width;
    } pulse_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    pulse_t      obs[$];
    pulse_t      exp_q[$];
    pulse_t      cur;
    bit          in_pulse = 0;

    // Pulse recorder: cyc equals the index of the edge just taken.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (pwm != '0) begin
            if (!in_pulse) begin
                in_pulse  = 1;
                cur.start = cyc;
                cur.width = 1;
                cur.ch    = -1;
                for (int i = 0; i < N_CH; i++) if (pwm[i]) cur.ch = i;
                n_cmp++;
                if ($countones(pwm) != 1) begin
                    n_fail++;
                    $display("FAIL onehot got pwm=%b want exactly one bit", pwm);
                end
            end else begin
                cur.width++;
            end
        end else if (in_pulse) begin
            in_pulse = 0;
            obs.push_back(cur);
        end
    end

    int          m_ptr;
    int unsigned m_act_ton, m_act_toff, m_sh_ton, m_sh_toff;

    function automatic int next_ch(input int p, input logic [N_CH-1:0] m);
        for (int i = 1; i <= N_CH; i++) if (m[(p + i) % N_CH]) return (p + i) % N_CH;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_act_ton = 1; m_act_toff = MIN_TOFF; m_sh_ton = 1; m_sh_toff = MIN_TOFF;
    endtask

    // Expected schedule for n pulses after a start sampled on edge p0 with a constant mask.
    task automatic model_run(input int unsigned p0, input int n);
        int unsigned t;
        int          ch;
        exp_q.delete();
        t = p0 + m_act_toff;
        for (int k = 0; k < n; k++) begin
            ch = next_ch(m_ptr, chan_mask);
            m_ptr = ch;
            m_act_ton = m_sh_ton;
            m_act_toff = m_sh_toff;
            exp_q.push_back('{start: t, ch: ch, width: m_act_ton});
            t += m_act_ton + m_act_toff;
        end
    endtask

    int unsigned p0;
    logic        ack_a, ack_b, snap_q, snap_run;
    logic [N_CH-1:0] snap_pwm;
    bit          ok;

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cmd_if.machine_start = 0; cmd_if.machine_stop = 0;
        cmd_if.change_Ton = 0; cmd_if.change_Toff = 0;
        short_flag = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        obs.delete();
        model_reset();
    endtask

    task automatic set_ton(input int v);
        @(negedge clk);
        cmd_if.Ton_data = CNT_W'(v); cmd_if.change_Ton = 1;
        @(negedge clk);
        ack_a = cmd_if.change_Ton_ack; cmd_if.change_Ton = 0;
        @(negedge clk);
        ack_b = cmd_if.change_Ton_ack;
        m_sh_ton = (v == 0) ? 1 : v;
    endtask

    task automatic set_toff(input int v);
        @(negedge clk);
        cmd_if.Toff_data = CNT_W'(v); cmd_if.change_Toff = 1;
        @(negedge clk);
        ack_a = cmd_if.change_Toff_ack; cmd_if.change_Toff = 0;
        @(negedge clk);
        ack_b = cmd_if.change_Toff_ack;
        m_sh_toff = (v < MIN_TOFF) ? MIN_TOFF : v;
    endtask

    task automatic send_start();
        @(negedge clk);
        cmd_if.machine_start = 1; p0 = cyc + 1;
        @(negedge clk);
        ack_a = cmd_if.machine_start_ack; cmd_if.machine_start = 0;
        @(negedge clk);
        ack_b = cmd_if.machine_start_ack;
    endtask

    task automatic send_stop();
        @(negedge clk);
        cmd_if.machine_stop = 1;
        @(negedge clk);
        ack_a = cmd_if.machine_stop_ack; snap_pwm = pwm; snap_q = pwm_q; snap_run = running;
        cmd_if.machine_stop = 0;
        @(negedge clk);
        ack_b = cmd_if.machine_stop_ack;
    endtask

    task automatic wait_pulses(input int n, output bit done);
        done = 0;
        for (int i = 0; i < 4000; i++) begin
            if (obs.size() >= n) begin done = 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_high(output bit done);
        done = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (pwm != '0) begin done = 1; break; end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (pwm !== '0) begin n_fail++; $display("FAIL reset_pwm got %b want 0", pwm); end
        n_cmp++; if (pwm_q !== 1'b0) begin n_fail++; $display("FAIL reset_pwm_q got %b want 0", pwm_q); end
        n_cmp++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running got %b want 0", running); end
        n_cmp++; if (pulse_cnt !== '0) begin n_fail++; $display("FAIL reset_pulse_cnt got %0d want 0", pulse_cnt); end
        n_cmp++;
        if ({cmd_if.machine_start_ack, cmd_if.machine_stop_ack, cmd_if.change_Ton_ack, cmd_if.change_Toff_ack} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_acks got %b want 0000", {cmd_if.machine_start_ack, cmd_if.machine_stop_ack,
                     cmd_if.change_Ton_ack, cmd_if.change_Toff_ack});
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        chan_mask = 8'hFF;
        set_ton(10);
        n_cmp++; if (ack_a !== 1'b1 || ack_b !== 1'b0) begin n_fail++; $display("FAIL ton_ack got %b%b want 10", ack_a, ack_b); end
        set_toff(20);
        n_cmp++; if (ack_a !== 1'b1 || ack_b !== 1'b0) begin n_fail++; $display("FAIL toff_ack got %b%b want 10", ack_a, ack_b); end
        send_start();
        n_cmp++; if (ack_a !== 1'b1 || ack_b !== 1'b0) begin n_fail++; $display("FAIL start_ack got %b%b want 10", ack_a, ack_b); end
        model_run(p0, 8);
        wait_pulses(8, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rr_timeout got %0d pulses want 8", obs.size()); end
        n_cmp++; if (pulse_cnt !== 8) begin n_fail++; $display("FAIL rr_pulse_cnt got %0d want 8", pulse_cnt); end
        n_cmp++; if (pwm_q !== 1'b1 || running !== 1'b1) begin n_fail++; $display("FAIL rr_run got q=%b run=%b want 1 1", pwm_q, running); end
        for (int i = 0; i < 8 && i < obs.size(); i++) begin
            n_cmp++;
            if (obs[i].start !== exp_q[i].start || obs[i].ch !== exp_q[i].ch || obs[i].width !== exp_q[i].width) begin
                n_fail++;
                $display("FAIL rr_pulse[%0d] got start=%0d ch=%0d w=%0d want start=%0d ch=%0d w=%0d", i,
                         obs[i].start, obs[i].ch, obs[i].width, exp_q[i].start, exp_q[i].ch, exp_q[i].width);
            end
        end
        send_stop();
    endtask

    task automatic test_mask();
        apply_reset();
        chan_mask = 8'b0010_0100;
        set_ton(5);
        set_toff(6);
        send_start();
        model_run(p0, 4);
        wait_pulses(4, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL mask_timeout got %0d pulses want 4", obs.size()); end
        for (int i = 0; i < 4 && i < obs.size(); i++) begin
            n_cmp++;
            if (obs[i].start !== exp_q[i].start || obs[i].ch !== exp_q[i].ch || obs[i].width !== exp_q[i].width) begin
                n_fail++;
                $display("FAIL mask_pulse[%0d] got start=%0d ch=%0d w=%0d want start=%0d ch=%0d w=%0d", i,
                         obs[i].start, obs[i].ch, obs[i].width, exp_q[i].start, exp_q[i].ch, exp_q[i].width);
            end
        end
        chan_mask = '0;
        repeat (100) @(negedge clk);
        n_cmp++; if (obs.size() != 4) begin n_fail++; $display("FAIL mask_zero_pulses got %0d want 4", obs.size()); end
        n_cmp++; if (pwm_q !== 1'b1 || pwm !== '0) begin n_fail++; $display("FAIL mask_zero_out got q=%b pwm=%b want 1 0", pwm_q, pwm); end
        n_cmp++; if (pulse_cnt !== 4) begin n_fail++; $display("FAIL mask_zero_cnt got %0d want 4", pulse_cnt); end
        send_stop();
    endtask

    task automatic test_param_change();
        apply_reset();
        chan_mask = 8'hFF;
        set_ton(10);
        set_toff(20);
        send_start();
        wait_pulses(1, ok);
        wait_high(ok);
        set_ton(50);
        n_cmp++; if (ack_a !== 1'b1 || ack_b !== 1'b0) begin n_fail++; $display("FAIL midrun_ton_ack got %b%b want 10", ack_a, ack_b); end
        set_toff(0);
        wait_pulses(4, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL param_timeout got %0d pulses want 4", obs.size()); end
        if (obs.size() >= 4) begin
            n_cmp++; if (obs[1].width != 10) begin n_fail++; $display("FAIL param_cur_width got %0d want 10", obs[1].width); end
            n_cmp++;
            if (obs[2].start - (obs[1].start + obs[1].width) != 20) begin
                n_fail++; $display("FAIL param_gap1 got %0d want 20", obs[2].start - (obs[1].start + obs[1].width));
            end
            n_cmp++; if (obs[2].width != 50) begin n_fail++; $display("FAIL param_next_width got %0d want 50", obs[2].width); end
            n_cmp++;
            if (obs[3].start - (obs[2].start + obs[2].width) != MIN_TOFF) begin
                n_fail++; $display("FAIL param_toff_clamp got %0d want %0d", obs[3].start - (obs[2].start + obs[2].width), MIN_TOFF);
            end
            n_cmp++; if (obs[3].width != 50) begin n_fail++; $display("FAIL param_width2 got %0d want 50", obs[3].width); end
        end
        send_stop();
    endtask

    task automatic test_stop();
        apply_reset();
        chan_mask = 8'hFF;
        set_ton(10);
        set_toff(20);
        send_start();
        wait_high(ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL stop_no_pulse got none want pulse"); end
        send_stop();
        n_cmp++;
        if (snap_pwm !== '0 || snap_q !== 1'b0 || snap_run !== 1'b0) begin
            n_fail++; $display("FAIL stop_outputs got pwm=%b q=%b run=%b want 0 0 0", snap_pwm, snap_q, snap_run);
        end
        n_cmp++; if (ack_a !== 1'b1 || ack_b !== 1'b0) begin n_fail++; $display("FAIL stop_ack got %b%b want 10", ack_a, ack_b); end
        @(negedge clk);
        cmd_if.machine_start = 1; cmd_if.machine_stop = 1;
        @(negedge clk);
        cmd_if.machine_start = 0; cmd_if.machine_stop = 0;
        n_cmp++;
        if (cmd_if.machine_start_ack !== 1'b0 || cmd_if.machine_stop_ack !== 1'b1 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL start_stop_same got sack=%b pack=%b run=%b want 0 1 0",
                     cmd_if.machine_start_ack, cmd_if.machine_stop_ack, running);
        end
        send_stop();
        n_cmp++; if (ack_a !== 1'b1 || snap_run !== 1'b0) begin n_fail++; $display("FAIL idle_stop got ack=%b run=%b want 1 0", ack_a, snap_run); end
    endtask

    task automatic test_random();
        int ton, toff;
        for (int it = 0; it < 4; it++) begin
            apply_reset();
            ton  = (it == 0) ? 0 : int'($urandom_range(1, 12));
            toff = (it == 0) ? 0 : int'($urandom_range(0, 15));
            chan_mask = N_CH'($urandom_range(1, 255));
            set_ton(ton);
            set_toff(toff);
            send_start();
            model_run(p0, 6);
            wait_pulses(1, ok);
            send_start();
            n_cmp++; if (ack_a !== 1'b1) begin n_fail++; $display("FAIL rand_restart_ack[%0d] got %b want 1", it, ack_a); end
            wait_pulses(6, ok);
            n_cmp++; if (!ok) begin n_fail++; $display("FAIL rand_timeout[%0d] got %0d pulses want 6", it, obs.size()); end
            n_cmp++; if (pulse_cnt !== 6) begin n_fail++; $display("FAIL rand_cnt[%0d] got %0d want 6", it, pulse_cnt); end
            for (int i = 0; i < 6 && i < obs.size(); i++) begin
                n_cmp++;
                if (obs[i].start !== exp_q[i].start || obs[i].ch !== exp_q[i].ch || obs[i].width !== exp_q[i].width) begin
                    n_fail++;
                    $display("FAIL rand[%0d]_pulse[%0d] got start=%0d ch=%0d w=%0d want start=%0d ch=%0d w=%0d", it, i,
                             obs[i].start, obs[i].ch, obs[i].width, exp_q[i].start, exp_q[i].ch, exp_q[i].width);
                end
            end
            send_stop();
        end
    endtask

    task automatic test_short();
        int unsigned exp_w, exp_gap;
`ifdef SHORT_CUT_EN
        exp_w = 3; exp_gap = 40;
`else
        exp_w = 10; exp_gap = 20;
`endif
        apply_reset();
        chan_mask = 8'hFF;
        set_ton(10);
        set_toff(20);
        send_start();
        wait_high(ok);
        @(negedge clk);
        @(negedge clk);
        short_flag = 1;
        @(negedge clk);
        short_flag = 0;
        wait_pulses(3, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL short_timeout got %0d pulses want 3", obs.size()); end
        if (obs.size() >= 3) begin
            n_cmp++; if (obs[0].width != exp_w) begin n_fail++; $display("FAIL short_width got %0d want %0d", obs[0].width, exp_w); end
            n_cmp++;
            if (obs[1].start - (obs[0].start + obs[0].width) != exp_gap) begin
                n_fail++; $display("FAIL short_gap got %0d want %0d", obs[1].start - (obs[0].start + obs[0].width), exp_gap);
            end
            n_cmp++;
            if (obs[2].start - (obs[1].start + obs[1].width) != 20 || obs[1].width != 10) begin
                n_fail++; $display("FAIL short_revert got gap=%0d w=%0d want 20 10",
                                   obs[2].start - (obs[1].start + obs[1].width), obs[1].width);
            end
        end
        n_cmp++; if (pulse_cnt !== 3) begin n_fail++; $display("FAIL short_cnt got %0d want 3", pulse_cnt); end
        send_stop();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        chan_mask = 8'hFF;
        set_ton(10);
        set_toff(20);
        send_start();
        wait_high(ok);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (pwm !== '0 || pwm_q !== 1'b0 || running !== 1'b0 || pulse_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_mid got pwm=%b q=%b run=%b cnt=%0d want 0 0 0 0", pwm, pwm_q, running, pulse_cnt);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        cmd_if.machine_start = 0; cmd_if.machine_stop = 0;
        cmd_if.change_Ton = 0; cmd_if.change_Toff = 0;
        cmd_if.Ton_data = '0; cmd_if.Toff_data = '0;
        chan_mask = '0; short_flag = 0;
        test_reset();
        test_round_robin();
        test_mask();
        test_param_change();
        test_stop();
        test_random();
        test_short();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got no finish want finish before 90000 cycles");
        $fatal(1, "watchdog");
    end

endmodule
